// File: rtl/tape_transport.sv
// Cassette transport position engine: prescaled position ticks driven by
// STOP/PLAY/FFWD/REW modes, SEEK, a one-cycle-busy command handshake and end-of-tape rules.
module tape_transport #(
  parameter int POS_W    = 24,
  parameter int DIV_W    = 13,
  parameter int PRESCALE = 6667,
  parameter int FF_STEP  = 8,
  parameter int REW_STEP = 8
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [POS_W-1:0] cmd_arg,
  input  logic [POS_W-1:0] tape_end,
  input  logic             loop_en,
  output logic [POS_W-1:0] pos,
  output logic [1:0]       state,
  output logic             step_tick,
  output logic             at_start,
  output logic             at_end,
  output logic             motor_on
);

  typedef enum logic [1:0] {ST_STOP, ST_PLAY, ST_FFWD, ST_REW} state_e;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PRESCALE - 1);
  localparam logic [POS_W:0]   ONE_X    = (POS_W + 1)'(1);
  localparam logic [POS_W:0]   FF_X     = (POS_W + 1)'(FF_STEP);
  localparam logic [POS_W:0]   REW_X    = (POS_W + 1)'(REW_STEP);

  state_e           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             ready_q, ready_d;
  logic             step_q, step_d;

  logic             accept;
  logic             tick;
  logic [POS_W:0]   pos_x, end_x, play_n, ffwd_n, rew_n;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STOP;
      pos_q   <= '0;
      div_q   <= '0;
      ready_q <= 1'b1;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      div_q   <= div_d;
      ready_q <= ready_d;
      step_q  <= step_d;
    end
  end

  // Arithmetic is one bit wider so that pos+step cannot wrap before the end compare.
  always_comb begin
    accept  = cmd_valid & ready_q;
    tick    = (state_q != ST_STOP) && (div_q == DIV_LAST);
    pos_x   = {1'b0, pos_q};
    end_x   = {1'b0, tape_end};
    play_n  = pos_x + ONE_X;
    ffwd_n  = pos_x + FF_X;
    rew_n   = pos_x - REW_X;

    state_d = state_q;
    pos_d   = pos_q;
    div_d   = '0;
    ready_d = ~accept;
    step_d  = tick & ~accept;

    if (accept) begin
      case (cmd_op)
        3'd0, 3'd1, 3'd2, 3'd3: state_d = state_e'(cmd_op[1:0]);
        3'd4:    pos_d = (cmd_arg < tape_end) ? cmd_arg : tape_end;
        default: ;
      endcase
    end else if (tick) begin
      case (state_q)
        ST_PLAY: begin
          if (play_n > end_x) begin
            if (loop_en) begin
              pos_d = '0;
            end else begin
              pos_d   = tape_end;
              state_d = ST_STOP;
            end
          end else begin
            pos_d = play_n[POS_W-1:0];
          end
        end
        ST_FFWD: begin
          if (ffwd_n >= end_x) begin
            pos_d   = tape_end;
            state_d = ST_STOP;
          end else begin
            pos_d = ffwd_n[POS_W-1:0];
          end
        end
        ST_REW: begin
          if (pos_x <= REW_X) begin
            pos_d   = '0;
            state_d = ST_STOP;
          end else begin
            pos_d = rew_n[POS_W-1:0];
          end
        end
        default: ;
      endcase
    end else if (state_q != ST_STOP) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  assign cmd_ready = ready_q;
  assign pos       = pos_q;
  assign state     = state_q;
  assign step_tick = step_q;
  assign at_start  = (pos_q == '0);
  assign at_end    = (pos_q >= tape_end);
  assign motor_on  = (state_q != ST_STOP);

endmodule

// File: tb/tb_tape_transport.sv
// Bench for tape_transport: directed scenarios with literal expectations, then
// randomized commands checked every cycle against a behavioural position model.
module tb_tape_transport;

  localparam int POS_W    = 8;
  localparam int DIV_W    = 3;
  localparam int PRESCALE = 4;
  localparam int FF_STEP  = 8;
  localparam int REW_STEP = 8;

  logic             clk_sys = 1'b0;
  logic             reset_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [POS_W-1:0] cmd_arg;
  logic [POS_W-1:0] tape_end;
  logic             loop_en;
  logic [POS_W-1:0] pos;
  logic [1:0]       state;
  logic             step_tick;
  logic             at_start;
  logic             at_end;
  logic             motor_on;

  int errors = 0;
  int checks = 0;
  int step_count = 0;

  // Model: position, mode (0 STOP 1 PLAY 2 FFWD 3 REW), cycles of motion since the last tick/command.
  int m_pos, m_state, m_cnt;
  bit m_ready, m_step;

  always #5 clk_sys = ~clk_sys;

  tape_transport #(
    .POS_W(POS_W), .DIV_W(DIV_W), .PRESCALE(PRESCALE),
    .FF_STEP(FF_STEP), .REW_STEP(REW_STEP)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .tape_end(tape_end), .loop_en(loop_en),
    .pos(pos), .state(state), .step_tick(step_tick),
    .at_start(at_start), .at_end(at_end), .motor_on(motor_on)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_state = 0; m_cnt = 0; m_ready = 1'b1; m_step = 1'b0;
  endtask

  task automatic compare_all();
    check("pos", int'(pos), m_pos);
    check("state", int'(state), m_state);
    check("cmd_ready", int'(cmd_ready), int'(m_ready));
    check("step_tick", int'(step_tick), int'(m_step));
    check("at_start", int'(at_start), int'(m_pos == 0));
    check("at_end", int'(at_end), int'(m_pos >= int'(tape_end)));
    check("motor_on", int'(motor_on), int'(m_state != 0));
  endtask

  // Advance model by the rules for the inputs currently applied, clock once, compare.
  task automatic cycle();
    int te;
    bit acc, tk;
    te  = int'(tape_end);
    acc = cmd_valid && m_ready;
    tk  = (m_state != 0) && (m_cnt == PRESCALE - 1);
    m_ready = !acc;
    m_step  = tk && !acc;
    if (acc) begin
      m_cnt = 0;
      if (cmd_op <= 3'd3) m_state = int'(cmd_op);
      else if (cmd_op == 3'd4) m_pos = (int'(cmd_arg) < te) ? int'(cmd_arg) : te;
    end else if (tk) begin
      m_cnt = 0;
      if (m_state == 1) begin
        if (m_pos + 1 > te) begin
          if (loop_en) m_pos = 0;
          else begin m_pos = te; m_state = 0; end
        end else m_pos = m_pos + 1;
      end else if (m_state == 2) begin
        if (m_pos + FF_STEP >= te) begin m_pos = te; m_state = 0; end
        else m_pos = m_pos + FF_STEP;
      end else begin
        if (m_pos <= REW_STEP) begin m_pos = 0; m_state = 0; end
        else m_pos = m_pos - REW_STEP;
      end
    end else begin
      m_cnt = (m_state != 0) ? m_cnt + 1 : 0;
    end
    @(posedge clk_sys);
    @(negedge clk_sys);
    compare_all();
    if (step_tick) step_count++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // One idle cycle guarantees cmd_ready is high, then the command is presented for one cycle.
  task automatic issue_cmd(input int op, input int arg);
    cmd_valid = 1'b0;
    cycle();
    cmd_valid = 1'b1;
    cmd_op    = 3'(op);
    cmd_arg   = POS_W'(arg);
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 model_reset();
    compare_all();
    check("rst_pos", int'(pos), 0);
    check("rst_state", int'(state), 0);
    check("rst_ready", int'(cmd_ready), 1);
    @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    compare_all();
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_arg = '0;
    tape_end = POS_W'(10); loop_en = 1'b0;
    #1 model_reset();
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    compare_all();
    check("init_pos", int'(pos), 0);
    check("init_ready", int'(cmd_ready), 1);

    // PLAY from 0 without loop: ten ticks to 10, then end rule stops the tape.
    issue_cmd(1, 0);
    step_count = 0;
    run(40);
    check("s1_ticks", step_count, 10);
    check("s1_pos", int'(pos), 10);
    check("s1_state_play", int'(state), 1);
    run(4);
    check("s1_end_pos", int'(pos), 10);
    check("s1_end_state", int'(state), 0);

    // PLAY with loop: 8 -> 9 -> 10 -> 0, stays in PLAY.
    loop_en = 1'b1;
    issue_cmd(4, 8);
    issue_cmd(1, 0);
    run(4); check("s2_pos9", int'(pos), 9);
    run(4); check("s2_pos10", int'(pos), 10);
    run(4); check("s2_wrap", int'(pos), 0);
    check("s2_state", int'(state), 1);

    // FFWD from 5 clamps to end and stops; REW from 10 goes 2 then 0.
    loop_en = 1'b0;
    issue_cmd(0, 0);
    issue_cmd(4, 5);
    issue_cmd(2, 0);
    run(4); check("s3_ff_pos", int'(pos), 10);
    check("s3_ff_state", int'(state), 0);
    issue_cmd(3, 0);
    run(4); check("s3_rew_pos2", int'(pos), 2);
    run(4); check("s3_rew_pos0", int'(pos), 0);
    check("s3_rew_state", int'(state), 0);

    // SEEK beyond end while playing: clipped, handshake busy one cycle, prescaler restarted.
    loop_en = 1'b1;
    issue_cmd(1, 0);
    run(2);
    issue_cmd(4, 20);
    check("s4_seek_pos", int'(pos), 10);
    check("s4_ready_low", int'(cmd_ready), 0);
    run(3); check("s4_no_tick_yet", int'(pos), 10);
    run(1); check("s4_tick_after_seek", int'(pos), 0);

    // PLAY presented exactly on a FFWD tick: command wins, tick dropped.
    issue_cmd(4, 3);
    issue_cmd(2, 0);
    run(2);
    issue_cmd(1, 0);
    check("s5_pos", int'(pos), 3);
    check("s5_state", int'(state), 1);
    check("s5_no_step", int'(step_tick), 0);

    // Asynchronous reset in the middle of FFWD.
    issue_cmd(2, 0);
    run(2);
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      cmd_valid = ($urandom_range(0, 9) < 3);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_arg   = POS_W'($urandom_range(0, 20));
      if ($urandom_range(0, 99) == 0) tape_end = POS_W'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) loop_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
